// File: rtl/alu_operand_fetch_if.sv
// Operand-fetch stage bus: upstream issue, ALU-side issue and writeback return.
interface alu_operand_fetch_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [AW-1:0]   in_rs1;
  logic [AW-1:0]   in_rs2;
  logic [AW-1:0]   in_rd;
  logic            in_use_imm;
  logic [XLEN-1:0] in_imm;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_op;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [AW-1:0]   out_rd;

  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            err_illegal;

  // Environment side: drives ops, ALU ready and writebacks.
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    output out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_op, out_a, out_b, out_rd, err_illegal
  );

  // Stage side.
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    input  out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_op, out_a, out_b, out_rd, err_illegal
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// Operand fetch / issue stage feeding the 64-bit ALU: register file with
// writeback bypass, busy scoreboard, and a single registered issue slot.
module alu_operand_fetch #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input logic               clk,
  input logic               rst,
  alu_operand_fetch_if.slave bus
);

  localparam int unsigned OPW     = 4;
  localparam int unsigned OP_LAST = 9;

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic            out_valid_q;
  logic [OPW-1:0]  out_op_q;
  logic [XLEN-1:0] out_a_q;
  logic [XLEN-1:0] out_b_q;
  logic [AW-1:0]   out_rd_q;
  logic            err_q;

  logic            wb_hit_rs1;
  logic            wb_hit_rs2;
  logic            wb_hit_rd;
  logic            hz;
  logic            ready;
  logic            accept;
  logic            legal;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] opb;

  // Hazard detection, handshake and operand selection with writeback bypass.
  always_comb begin
    wb_hit_rs1 = bus.wb_en && (bus.wb_rd == bus.in_rs1);
    wb_hit_rs2 = bus.wb_en && (bus.wb_rd == bus.in_rs2);
    wb_hit_rd  = bus.wb_en && (bus.wb_rd == bus.in_rd);
    hz = (busy[bus.in_rs1] && !wb_hit_rs1)
       || (busy[bus.in_rs2] && !wb_hit_rs2 && !bus.in_use_imm)
       || (busy[bus.in_rd]  && !wb_hit_rd);
    ready  = !rst && !hz && (!out_valid_q || bus.out_ready);
    accept = bus.in_valid && ready;
    legal  = (bus.in_op <= OPW'(OP_LAST));

    opa = '0;
    if (bus.in_rs1 != '0) begin
      opa = wb_hit_rs1 ? bus.wb_data : rf[bus.in_rs1];
    end
    rs2_val = '0;
    if (bus.in_rs2 != '0) begin
      rs2_val = wb_hit_rs2 ? bus.wb_data : rf[bus.in_rs2];
    end
    opb = bus.in_use_imm ? bus.in_imm : rs2_val;
  end

  // Scoreboard update: writeback clears, a legal accept sets and wins over a clear.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_en) begin
      busy_nxt[bus.wb_rd] = 1'b0;
    end
    if (accept && legal && (bus.in_rd != '0)) begin
      busy_nxt[bus.in_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Register file; x0 is never written and reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_rd != '0)) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Issue slot: loads on a legal accept, drains on ALU ready, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
    end else if (accept && legal) begin
      out_valid_q <= 1'b1;
      out_op_q    <= bus.in_op;
      out_a_q     <= opa;
      out_b_q     <= opb;
      out_rd_q    <= bus.in_rd;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // One-cycle pulse for an accepted-and-dropped illegal op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !legal;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = out_op_q;
  assign bus.out_a       = out_a_q;
  assign bus.out_b       = out_b_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.err_illegal = err_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: scoreboard of expected issued ops plus
// per-scenario handshake checks.
module tb_alu_operand_fetch;

  logic clk;
  logic rst;

  alu_operand_fetch_if #(.XLEN(64), .AW(5)) f ();

  alu_operand_fetch #(.XLEN(64), .NREG(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [63:0] m_rf [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference register file.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= 64'd0;
    end else if (f.wb_en && f.wb_rd != 5'd0) begin
      m_rf[f.wb_rd] <= f.wb_data;
    end
  end

  function automatic logic [63:0] src_val(input logic [4:0] r);
    if (r == 5'd0) return 64'd0;
    if (f.wb_en && f.wb_rd == r) return f.wb_data;
    return m_rf[r];
  endfunction

  // Scoreboard pop on every ALU-side transfer.
  always @(negedge clk) begin
    if (!rst && f.out_valid === 1'b1 && f.out_ready === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: op=%0d a=%h rd=%0d, required no issue", f.out_op, f.out_a, f.out_rd);
      end else begin
        mon_e = sb.pop_front();
        if (f.out_op !== mon_e.op || f.out_a !== mon_e.a || f.out_b !== mon_e.b || f.out_rd !== mon_e.rd) begin
          n_fail++;
          $display("FAIL issue_data: got op=%0d a=%h b=%h rd=%0d, required op=%0d a=%h b=%h rd=%0d",
                   f.out_op, f.out_a, f.out_b, f.out_rd, mon_e.op, mon_e.a, mon_e.b, mon_e.rd);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1);
  end

  task automatic set_op(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic use_imm, input logic [63:0] imm);
    f.in_valid = 1'b1; f.in_op = op; f.in_rs1 = rs1; f.in_rs2 = rs2;
    f.in_rd = rd; f.in_use_imm = use_imm; f.in_imm = imm;
  endtask

  // One cycle; records an expected issue when the stage accepts a legal op.
  task automatic step_issue(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = (f.in_valid === 1'b1) && (f.in_ready === 1'b1);
    if (acc && f.in_op <= 4'd9) begin
      e.op = f.in_op; e.a = src_val(f.in_rs1);
      e.b = f.in_use_imm ? f.in_imm : src_val(f.in_rs2);
      e.rd = f.in_rd;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [63:0] d);
    f.in_valid = 1'b0; f.wb_en = 1'b1; f.wb_rd = rd; f.wb_data = d;
    @(posedge clk); #1;
    f.wb_en = 1'b0;
  endtask

  task automatic drain();
    f.in_valid = 1'b0; f.wb_en = 1'b0; f.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    bit acc;
    @(negedge clk);
    n_tests++;
    if (f.in_ready !== 1'b0 || f.out_valid !== 1'b0 || f.err_illegal !== 1'b0 ||
        f.out_a !== 64'd0 || f.out_b !== 64'd0 || f.out_op !== 4'd0 || f.out_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b err=%b a=%h b=%h op=%0d rd=%0d, required all 0",
               f.in_ready, f.out_valid, f.err_illegal, f.out_a, f.out_b, f.out_op, f.out_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_wb(5'd5, 64'h5555);
    f.out_ready = 1'b0;
    set_op(4'd0, 5'd0, 5'd0, 5'd9, 1'b0, 64'd0);
    step_issue(acc);
    f.in_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL reset_pre_accept: accepted=%b, required 1", acc); end
    @(negedge clk);
    n_tests++;
    if (f.out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_valid: out_valid=%b, required 1", f.out_valid); end
    rst = 1'b1;
    #1;
    sb.delete();
    n_tests++;
    if (f.out_valid !== 1'b0 || f.in_ready !== 1'b0 || f.out_a !== 64'd0 || f.out_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_issue: out_valid=%b in_ready=%b a=%h rd=%0d, required 0 0 0 0",
               f.out_valid, f.in_ready, f.out_a, f.out_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    f.out_ready = 1'b1;
    set_op(4'd0, 5'd5, 5'd9, 5'd9, 1'b0, 64'd0);
    step_issue(acc);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL reset_busy_cleared: accepted=%b, required 1", acc); end
    f.in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (f.out_a !== 64'd0) begin n_fail++; $display("FAIL reset_x5_read: out_a=%h, required 0", f.out_a); end
    @(posedge clk); #1;
    do_wb(5'd9, 64'h9);
  endtask

  task automatic test_bypass();
    bit acc;
    drain();
    f.wb_en = 1'b1; f.wb_rd = 5'd3; f.wb_data = 64'h1234;
    set_op(4'd0, 5'd3, 5'd0, 5'd4, 1'b0, 64'd0);
    step_issue(acc);
    f.wb_en = 1'b0; f.in_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL bypass_accept: accepted=%b, required 1", acc); end
    @(negedge clk);
    n_tests++;
    if (f.out_valid !== 1'b1 || f.out_a !== 64'h1234) begin
      n_fail++; $display("FAIL bypass_value: out_valid=%b out_a=%h, required 1 1234", f.out_valid, f.out_a);
    end
    @(posedge clk); #1;
    do_wb(5'd4, 64'h44);
  endtask

  task automatic test_raw_stall();
    bit acc;
    drain();
    do_wb(5'd1, 64'h11);
    do_wb(5'd2, 64'h22);
    set_op(4'd0, 5'd1, 5'd2, 5'd7, 1'b0, 64'd0);
    step_issue(acc);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL raw_producer: accepted=%b, required 1", acc); end
    set_op(4'd1, 5'd7, 5'd2, 5'd8, 1'b0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step_issue(acc);
      n_tests++;
      if (acc !== 1'b0) begin n_fail++; $display("FAIL raw_stall cycle %0d: accepted=%b, required 0", k, acc); end
    end
    f.wb_en = 1'b1; f.wb_rd = 5'd7; f.wb_data = 64'hABCD;
    step_issue(acc);
    f.wb_en = 1'b0; f.in_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL raw_release: accepted=%b, required 1", acc); end
    @(negedge clk);
    n_tests++;
    if (f.out_a !== 64'hABCD || f.out_op !== 4'd1) begin
      n_fail++; $display("FAIL raw_bypass: out_a=%h op=%0d, required abcd 1", f.out_a, f.out_op);
    end
    @(posedge clk); #1;
    do_wb(5'd8, 64'h88);
  endtask

  task automatic test_backpressure();
    bit acc;
    drain();
    f.out_ready = 1'b0;
    set_op(4'd2, 5'd1, 5'd2, 5'd10, 1'b0, 64'd0);
    step_issue(acc);
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_first_accept: accepted=%b, required 1", acc); end
    set_op(4'd4, 5'd2, 5'd0, 5'd11, 1'b1, 64'h55);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (f.in_ready !== 1'b0 || f.out_valid !== 1'b1 || f.out_op !== 4'd2 ||
          f.out_a !== 64'h11 || f.out_b !== 64'h22 || f.out_rd !== 5'd10) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: in_ready=%b valid=%b op=%0d a=%h b=%h rd=%0d, required 0 1 2 11 22 10",
                 k, f.in_ready, f.out_valid, f.out_op, f.out_a, f.out_b, f.out_rd);
      end
      @(posedge clk); #1;
    end
    f.out_ready = 1'b1;
    step_issue(acc);
    f.in_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL bp_resume_accept: accepted=%b, required 1", acc); end
    @(posedge clk); #1;
    do_wb(5'd10, 64'hA0);
    do_wb(5'd11, 64'hB0);
  endtask

  task automatic test_x0();
    bit acc;
    drain();
    do_wb(5'd0, 64'hFFFF);
    f.wb_en = 1'b1; f.wb_rd = 5'd0; f.wb_data = 64'hFFFF;
    set_op(4'd3, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step_issue(acc);
      f.wb_en = 1'b0;
      n_tests++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall cycle %0d: accepted=%b, required 1", k, acc); end
    end
    f.in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (f.out_a !== 64'd0 || f.out_b !== 64'd0) begin
      n_fail++; $display("FAIL x0_operands: a=%h b=%h, required 0 0", f.out_a, f.out_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    bit acc;
    drain();
    set_op(4'd12, 5'd1, 5'd2, 5'd13, 1'b0, 64'd0);
    step_issue(acc);
    f.in_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL illegal_accept: accepted=%b, required 1", acc); end
    @(negedge clk);
    n_tests++;
    if (f.err_illegal !== 1'b1 || f.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse: err=%b out_valid=%b, required 1 0", f.err_illegal, f.out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (f.err_illegal !== 1'b0 || f.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse_end: err=%b out_valid=%b, required 0 0", f.err_illegal, f.out_valid);
    end
    @(posedge clk); #1;
    set_op(4'd0, 5'd13, 5'd13, 5'd14, 1'b0, 64'd0);
    step_issue(acc);
    f.in_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL illegal_no_busy: accepted=%b, required 1", acc); end
    @(posedge clk); #1;
    do_wb(5'd14, 64'hE0);
  endtask

  task automatic test_set_wins();
    bit acc;
    drain();
    f.wb_en = 1'b1; f.wb_rd = 5'd15; f.wb_data = 64'h77;
    set_op(4'd0, 5'd1, 5'd2, 5'd15, 1'b0, 64'd0);
    step_issue(acc);
    f.wb_en = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL setwin_accept: accepted=%b, required 1", acc); end
    set_op(4'd5, 5'd15, 5'd0, 5'd16, 1'b1, 64'd3);
    for (int k = 0; k < 2; k++) begin
      step_issue(acc);
      n_tests++;
      if (acc !== 1'b0) begin n_fail++; $display("FAIL setwin_stall cycle %0d: accepted=%b, required 0", k, acc); end
    end
    f.wb_en = 1'b1; f.wb_rd = 5'd15; f.wb_data = 64'h99;
    step_issue(acc);
    f.wb_en = 1'b0; f.in_valid = 1'b0;
    n_tests++;
    if (acc !== 1'b1) begin n_fail++; $display("FAIL setwin_release: accepted=%b, required 1", acc); end
    @(posedge clk); #1;
    do_wb(5'd16, 64'h16);
  endtask

  task automatic test_back_to_back();
    bit acc;
    drain();
    do_wb(5'd1, {$urandom, $urandom});
    do_wb(5'd2, {$urandom, $urandom});
    for (int i = 0; i < 8; i++) begin
      set_op(4'(i % 10), 5'(1 + i % 2), 5'd2, 5'(20 + i), 1'(i % 2), {$urandom, $urandom});
      step_issue(acc);
      n_tests++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept op %0d: accepted=%b, required 1", i, acc); end
    end
    f.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) do_wb(5'(20 + i), 64'(i));
  endtask

  initial begin
    rst = 1'b1;
    f.in_valid = 1'b0; f.in_op = 4'd0; f.in_rs1 = 5'd0; f.in_rs2 = 5'd0; f.in_rd = 5'd0;
    f.in_use_imm = 1'b0; f.in_imm = 64'd0; f.out_ready = 1'b1;
    f.wb_en = 1'b0; f.wb_rd = 5'd0; f.wb_data = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_raw_stall();
    test_backpressure();
    test_x0();
    test_illegal();
    test_set_wins();
    test_back_to_back();
    drain();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d ops never issued, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
